// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer FSM states, mode codes
// and the sample-edge selection helper.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_DONE
  } spi_state_e;

  // Mode code is {CPOL, CPHA}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  function automatic logic is_sample_edge(
    input logic cpha,
    input logic leading
  );
    return leading ^ cpha;
  endfunction

endpackage

// File: rtl/spi_half_period_cnt.sv
// SCLK half-period divider: counts 0..ClkDiv-1 and flags
// the last cycle of each half-period.
module spi_half_period_cnt #(
  parameter int ClkDiv = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic Clr,
  output logic HalfTick
);

  localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] Last = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign HalfTick = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (Clr || HalfTick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer controller: CS framing, SCLK
// generation and sample/launch strobes for the shifters.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int WordLen = 8,
  parameter int ClkDiv  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic Start,
  input  logic CPOL,
  input  logic CPHA,
  output logic SCLK,
  output logic CS_n,
  output logic SCLKEdgeFlg,
  output logic ShiftEdgeFlg,
  output logic EnSIPO,
  output logic Busy,
  output logic Done
);

  localparam int EcntW = $clog2(2 * WordLen + 1);
  localparam logic [EcntW-1:0] LastEdge =
    EcntW'(2 * WordLen - 1);

  spi_state_e      state_q;
  logic            cpol_q, cpha_q;
  logic            sclk_q, csn_q, busy_q, done_q;
  logic            sflg_q, shflg_q, en_q;
  logic [EcntW-1:0] ecnt_q;

  logic half_tick, clr;
  logic last_edge, leading, samp, shft;

  // Edge number ecnt_q+1 is odd for leading edges
  assign last_edge = (ecnt_q == LastEdge);
  assign leading   = ~ecnt_q[0];
  assign samp      = is_sample_edge(cpha_q, leading);
  assign shft      = cpha_q ? leading
                            : (~leading & ~last_edge);

  always_comb begin
    clr = 1'b1;
    unique case (state_q)
      S_LEAD, S_TRAIL: clr = half_tick;
      S_SHIFT:         clr = half_tick & last_edge;
      default:         clr = 1'b1;
    endcase
  end

  spi_half_period_cnt #(
    .ClkDiv(ClkDiv)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .Clr     (clr),
    .HalfTick(half_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sflg_q  <= 1'b0;
      shflg_q <= 1'b0;
      en_q    <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      sflg_q  <= 1'b0;
      shflg_q <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cpol_q <= CPOL;
          sclk_q <= CPOL;
          ecnt_q <= '0;
          if (Start) begin
            cpha_q  <= CPHA;
            state_q <= S_LEAD;
            csn_q   <= 1'b0;
            busy_q  <= 1'b1;
            shflg_q <= ~CPHA;
          end
        end
        S_LEAD: begin
          if (half_tick) begin
            state_q <= S_SHIFT;
            en_q    <= 1'b1;
          end
        end
        S_SHIFT: begin
          en_q <= 1'b1;
          if (half_tick) begin
            sclk_q  <= ~sclk_q;
            ecnt_q  <= ecnt_q + 1'b1;
            sflg_q  <= samp;
            shflg_q <= shft;
            if (last_edge) begin
              state_q <= S_TRAIL;
              en_q    <= samp;
            end
          end
        end
        S_TRAIL: begin
          if (half_tick) begin
            state_q <= S_DONE;
            csn_q   <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          sclk_q  <= cpol_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign SCLK         = sclk_q;
  assign CS_n         = csn_q;
  assign SCLKEdgeFlg  = sflg_q;
  assign ShiftEdgeFlg = shflg_q;
  assign EnSIPO       = en_q;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a behavioural slave
// and receive shift register on the strobes.
module tb_spi_xfer_ctrl;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic Start = 1'b0;
  logic CPOL = 1'b0;
  logic CPHA = 1'b0;
  logic SCLK, CS_n, SCLKEdgeFlg, ShiftEdgeFlg;
  logic EnSIPO, Busy, Done;

  spi_xfer_ctrl #(.WordLen(8), .ClkDiv(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .Start       (Start),
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .SCLK        (SCLK),
    .CS_n        (CS_n),
    .SCLKEdgeFlg (SCLKEdgeFlg),
    .ShiftEdgeFlg(ShiftEdgeFlg),
    .EnSIPO      (EnSIPO),
    .Busy        (Busy),
    .Done        (Done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Slave drives MISO on launch strobes; receiver samples it
  logic [7:0] tx_data = 8'h00;
  bit         endiannes = 1'b1;
  int         sidx;
  logic       miso;
  logic [7:0] rx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sidx <= 0;
      miso <= 1'b0;
      rx   <= 8'h00;
    end else if (Start && !Busy) begin
      sidx <= 0;
      rx   <= 8'h00;
    end else begin
      if (ShiftEdgeFlg && sidx < 8) begin
        miso <= endiannes ? tx_data[7-sidx] : tx_data[sidx];
        sidx <= sidx + 1;
      end
      if (EnSIPO && SCLKEdgeFlg)
        rx <= endiannes ? {rx[6:0], miso} : {miso, rx[7:1]};
    end
  end

  int m_busy, m_done_cyc, m_ndone, m_done_csn;
  int m_tog, m_samp, m_samp_hi, m_shift, m_shift_hi;
  int m_en, m_enbad, m_cs_first, m_lead_sclk;
  int m_end_sclk, m_post_sclk, m_timeout;

  // Called at a negedge; Start is sampled on the next edge
  task automatic run_xfer(input logic [1:0] mode,
                          input logic [7:0] data,
                          input bit msb,
                          input int pulse_at,
                          input bit pulse_done,
                          input int flip_at);
    int cyc;
    logic prev;
    tx_data = data;
    endiannes = msb;
    CPOL = mode[1];
    CPHA = mode[0];
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    cyc = 1;
    prev = mode[1];
    m_busy = 0; m_done_cyc = 0; m_ndone = 0; m_done_csn = 0;
    m_tog = 0; m_samp = 0; m_samp_hi = 0;
    m_shift = 0; m_shift_hi = 0; m_en = 0; m_enbad = 0;
    m_end_sclk = 0;
    m_cs_first = int'(CS_n);
    m_lead_sclk = int'(SCLK);
    while (Busy && cyc < 100) begin
      m_busy++;
      if (SCLK != prev) m_tog++;
      prev = SCLK;
      if (SCLKEdgeFlg) begin
        m_samp++;
        if (SCLK) m_samp_hi++;
      end
      if (ShiftEdgeFlg) begin
        m_shift++;
        if (SCLK) m_shift_hi++;
      end
      if (EnSIPO) m_en++;
      if (SCLKEdgeFlg && !EnSIPO) m_enbad++;
      if (Done) begin
        m_ndone++;
        m_done_cyc = cyc;
        m_done_csn = int'(CS_n);
        m_end_sclk = int'(SCLK);
      end
      Start = (cyc == pulse_at) || (Done && pulse_done);
      if (cyc == flip_at) begin
        CPOL = ~CPOL;
        CPHA = ~CPHA;
      end
      @(negedge clk);
      cyc++;
    end
    m_timeout = int'(Busy);
    m_post_sclk = int'(SCLK);
    Start = 1'b0;
  endtask

  task automatic chk_xfer(input string p, input logic [7:0] data,
                          input bit idle, input int samp_hi,
                          input int shift_hi, input int en);
    chk({p, "_cs_first"}, m_cs_first, 0);
    chk({p, "_lead_sclk"}, m_lead_sclk, int'(idle));
    chk({p, "_busy"}, m_busy, 37);
    chk({p, "_done_cyc"}, m_done_cyc, 37);
    chk({p, "_ndone"}, m_ndone, 1);
    chk({p, "_done_csn"}, m_done_csn, 1);
    chk({p, "_toggles"}, m_tog, 16);
    chk({p, "_samp"}, m_samp, 8);
    chk({p, "_samp_hi"}, m_samp_hi, samp_hi);
    chk({p, "_shift"}, m_shift, 8);
    chk({p, "_shift_hi"}, m_shift_hi, shift_hi);
    chk({p, "_en"}, m_en, en);
    chk({p, "_enbad"}, m_enbad, 0);
    chk({p, "_end_sclk"}, m_end_sclk, int'(idle));
    chk({p, "_post_sclk"}, m_post_sclk, int'(idle));
    chk({p, "_timeout"}, m_timeout, 0);
    chk({p, "_rx"}, int'(rx), int'(data));
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] data;
    bit         msb;
    int         flip_at;
    bit         idle;
    int         samp_hi;
    int         shift_hi;
    int         en;
    bit         post;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nsf;
    vecs[0] = '{MODE0, 8'h5A, 1'b1, 0,  1'b0, 8, 0, 32, 1'b0};
    vecs[1] = '{MODE3, 8'hA5, 1'b1, 0,  1'b1, 8, 0, 33, 1'b1};
    vecs[2] = '{MODE1, 8'h3C, 1'b0, 0,  1'b0, 0, 8, 33, 1'b0};
    vecs[3] = '{MODE2, 8'hC3, 1'b0, 0,  1'b1, 0, 8, 32, 1'b1};
    vecs[4] = '{MODE0, 8'h96, 1'b1, 10, 1'b0, 8, 0, 32, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_sclk", int'(SCLK), 0);
    chk("rst_csn", int'(CS_n), 1);
    chk("rst_sflg", int'(SCLKEdgeFlg), 0);
    chk("rst_shflg", int'(ShiftEdgeFlg), 0);
    chk("rst_en", int'(EnSIPO), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].mode, vecs[i].data, vecs[i].msb,
               0, 1'b0, vecs[i].flip_at);
      chk_xfer($sformatf("v%0d", i), vecs[i].data,
               vecs[i].idle, vecs[i].samp_hi,
               vecs[i].shift_hi, vecs[i].en);
      @(negedge clk);
      chk($sformatf("v%0d_idle2", i), int'(SCLK),
          int'(vecs[i].post));
    end

    // Start during SHIFT and during DONE are both dropped
    run_xfer(MODE0, 8'h81, 1'b1, 10, 1'b1, 0);
    chk_xfer("ign", 8'h81, 1'b0, 8, 0, 32);
    chk("ign_busy_after_done", int'(Busy), 0);
    run_xfer(MODE0, 8'h7E, 1'b1, 0, 1'b0, 0);
    chk_xfer("next", 8'h7E, 1'b0, 8, 0, 32);

    // Asynchronous abort after the third sample strobe
    CPOL = 1'b0;
    CPHA = 1'b0;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    nsf = 0;
    for (int c = 0; c < 60 && nsf < 3; c++) begin
      if (SCLKEdgeFlg) nsf++;
      if (nsf < 3) @(negedge clk);
    end
    chk("abort_wait_sflg", nsf, 3);
    chk("abort_sclk_before", int'(SCLK), 1);
    rst = 1'b1;
    #1;
    chk("abort_csn", int'(CS_n), 1);
    chk("abort_sclk", int'(SCLK), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_en", int'(EnSIPO), 0);
    nsf = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (Done) nsf++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (Done || Busy) nsf++;
      @(negedge clk);
    end
    chk("abort_no_done", nsf, 0);
    run_xfer(MODE0, 8'hF0, 1'b1, 0, 1'b0, 0);
    chk_xfer("post_abort", 8'hF0, 1'b0, 8, 0, 32);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter WordLen, default 8, meaning bits per transfer (legal range >= 2).
REQ-002 SHALL have parameter ClkDiv, default 2, meaning clk cycles per SCLK half-period (legal range >= 1).
REQ-003 SHALL have port clk, input, 1, the single system clock; all flops on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port Start, input, 1, a transfer request sampled in IDLE.
REQ-006 SHALL have ports CPOL and CPHA, input, 1 each, selecting the SPI mode.
REQ-007 SHALL have port SCLK, output, 1, the serial clock to the slave.
REQ-008 SHALL have port CS_n, output, 1, the active-low slave select.
REQ-009 SHALL have port SCLKEdgeFlg, output, 1, a one-clk pulse on each sample edge, feeding the receive shift register.
REQ-010 SHALL have port ShiftEdgeFlg, output, 1, a one-clk pulse on each MOSI launch point, feeding the transmit shift register.
REQ-011 SHALL have port EnSIPO, output, 1, the receive shift-register enable.
REQ-012 SHALL have ports Busy and Done, output, 1 each: Busy marks a transfer in progress; Done is a one-clk completion pulse.

Function
REQ-013 SHALL implement FSM IDLE -> LEAD -> SHIFT -> TRAIL -> DONE -> IDLE.
REQ-014 In IDLE, Start=1 at a clk edge SHALL latch CPHA, enter LEAD, and drive CS_n=0 and Busy=1 from the next cycle.
REQ-015 LEAD and TRAIL SHALL each last exactly ClkDiv cycles with SCLK at idle level.
REQ-016 SHIFT SHALL last 2*WordLen*ClkDiv cycles; SCLK SHALL toggle at the end of every ClkDiv-cycle half-period, giving 2*WordLen toggles and ending at idle level.
REQ-017 Idle level SHALL be CPOL_q; CPOL_q SHALL be registered from CPOL every cycle in IDLE and held constant otherwise.
REQ-018 Sample edge SHALL be the leading (idle-to-active) edge when CPHA_q=0 and the trailing edge when CPHA_q=1.
REQ-019 SCLKEdgeFlg SHALL be high in exactly the cycle SCLK first shows the new sampling-edge level, exactly WordLen pulses per transfer.
REQ-020 ShiftEdgeFlg SHALL pulse for the following: when CPHA_q=0, once in the first LEAD cycle and then on every trailing edge except the last; when CPHA_q=1, on every leading edge. This gives WordLen pulses per transfer.
REQ-021 EnSIPO SHALL be 1 in SHIFT and in every cycle in which SCLKEdgeFlg=1, and 0 otherwise.
REQ-022 In DONE, the block SHALL drive CS_n=1, Done=1 and Busy=1 for one cycle, then return to IDLE.
REQ-023 Total Busy duration SHALL be (2*WordLen+2)*ClkDiv+1 cycles; the default is 37.
REQ-024 Start SHALL be ignored outside IDLE, including in the DONE cycle; no request is queued.
REQ-025 Changes on CPOL or CPHA outside IDLE SHALL have no effect on the current transfer.
REQ-026 The bit counter SHALL be ceil(log2(2*WordLen+1)) bits wide and SHALL reach exactly 2*WordLen edges with no wrap.
REQ-027 The divider counter SHALL count 0..ClkDiv-1, wrap to 0, and be cleared on every state entry.

Reset
REQ-028 While rst=1, the state SHALL be IDLE and outputs SHALL be: SCLK=0, CS_n=1, SCLKEdgeFlg=0, ShiftEdgeFlg=0, EnSIPO=0, Busy=0, Done=0.
REQ-029 Internal reset state SHALL be CPOL_q=0, CPHA_q=0, and both counters at 0.
REQ-030 Reset mid-transfer SHALL abort the transfer immediately (asynchronously), with no Done pulse.
REQ-031 After reset release, the first Start SHALL be accepted on the first clk edge.

Structure
REQ-032 State encoding and mode constants (MODE0..MODE3) SHALL reside in shared package spi_pkg.
REQ-033 The half-period divider SHALL be sub-module spi_half_period_cnt (parameter ClkDiv; inputs clk, rst, Clr; output HalfTick).
REQ-034 The block SHALL be instantiated beside the receive shift register, with SCLKEdgeFlg and EnSIPO wired directly to it.

Verification
REQ-035 Mode 0, WordLen=8, ClkDiv=2, one-cycle Start: CS_n low 1 cycle later, 16 SCLK toggles, 8 SCLKEdgeFlg pulses on rising SCLK, Done at cycle 37, Busy high 37 cycles.
REQ-036 Mode 3, MISO driven 0xA5 MSB-first with receiver Endiannes=1: SCLK idles 1, samples on rising edges, receiver reads 0xA5 after Done.
REQ-037 Mode 1, MISO 0x3C LSB-first with Endiannes=0: receiver reads 0x3C; ShiftEdgeFlg pulses 8 times, all on rising SCLK.
REQ-038 Start re-pulsed during SHIFT and again in the DONE cycle: both ignored; Start in the next IDLE cycle begins a new 37-cycle transfer.
REQ-039 rst asserted after the 3rd SCLKEdgeFlg: same-cycle CS_n=1, SCLK=0, Busy=0, no Done; a later Start completes a normal transfer.
REQ-040 CPOL toggled mid-transfer: SCLK waveform unchanged; the idle level follows the new CPOL one cycle after return to IDLE.
